// File: rtl/iir_pkg.sv
// iir_pkg: shared FSM states, tap indices and accumulator sizing for the SOS cascade
package iir_pkg;
    typedef enum logic [1:0] {S_IDLE, S_MAC, S_WB, S_OUT} state_t;
    localparam int NTAP = 5;
    localparam logic [2:0] TAP_B0 = 3'd0;
    localparam logic [2:0] TAP_B1 = 3'd1;
    localparam logic [2:0] TAP_B2 = 3'd2;
    localparam logic [2:0] TAP_A1 = 3'd3;
    localparam logic [2:0] TAP_A2 = 3'd4;
    function automatic int acc_width(input int wi, input int wf, input int guard);
        return 2 * (wi + wf) + guard;
    endfunction
endpackage

// File: rtl/iir_round_sat.sv
// iir_round_sat: round half up, shift right by WF and saturate an accumulator to WI+WF bits
//   i_acc : signed accumulator, AW bits
//   o_y   : rounded and saturated result, Q(WI.WF)
//   o_sat : high when o_y was clipped
module iir_round_sat #(
    parameter int WI = 5,
    parameter int WF = 11,
    parameter int AW = 36
) (
    input  logic signed [AW-1:0]    i_acc,
    output logic signed [WI+WF-1:0] o_y,
    output logic                    o_sat
);
    localparam int W = WI + WF;
    localparam logic signed [AW:0] RND = {{(AW+1-WF){1'b0}}, 1'b1, {(WF-1){1'b0}}};
    // one extra bit so adding the rounding constant can never wrap
    logic signed [AW:0] w_sum;
    logic signed [AW:0] w_shr;
    assign w_sum = {i_acc[AW-1], i_acc} + RND;
    assign w_shr = w_sum >>> WF;
    // fits only if every bit above the result sign equals the sign
    assign o_sat = w_shr[AW:W-1] != {(AW-W+2){w_shr[AW]}};
    assign o_y   = o_sat ? {w_shr[AW], {(W-1){~w_shr[AW]}}} : w_shr[W-1:0];
endmodule

// File: rtl/iir_sos_cascade.sv
// iir_sos_cascade: NSEC Direct-Form-I biquads time-multiplexed on one signed MAC
//   i_clk, i_rst                  : clock, synchronous active-high reset
//   i_din, i_in_valid, o_in_ready : input sample stream, Q(WI.WF)
//   o_dout, o_out_valid, i_out_ready : output sample stream, Q(WI.WF)
//   i_coef_we, i_coef_addr, i_coef_data : coefficient write (addr = section*5 + tap), IDLE only
//   i_clear_state                 : zero delay lines and overflow flag, IDLE only
//   o_ovf                         : sticky saturation flag
module iir_sos_cascade
    import iir_pkg::*;
#(
    parameter int NSEC  = 4,
    parameter int WI    = 5,
    parameter int WF    = 11,
    parameter int GUARD = 4
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic signed [WI+WF-1:0]             i_din,
    input  logic                                i_in_valid,
    output logic                                o_in_ready,
    output logic signed [WI+WF-1:0]             o_dout,
    output logic                                o_out_valid,
    input  logic                                i_out_ready,
    input  logic                                i_coef_we,
    input  logic [$clog2(NTAP*NSEC)-1:0]        i_coef_addr,
    input  logic signed [WI+WF-1:0]             i_coef_data,
    input  logic                                i_clear_state,
    output logic                                o_ovf
);
    localparam int W   = WI + WF;
    localparam int AW  = acc_width(WI, WF, GUARD);
    localparam int NC  = NTAP * NSEC;
    localparam int CAW = $clog2(NC);
    localparam int SW  = NSEC > 1 ? $clog2(NSEC) : 1;
    localparam logic signed [W-1:0] ONE = W'(2 ** WF);

    state_t                r_state;
    logic [SW-1:0]         r_sec;
    logic [2:0]            r_tap;
    logic signed [AW-1:0]  r_acc;
    logic signed [W-1:0]   r_x;
    logic signed [W-1:0]   r_dout;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic                  r_ovf;
    logic signed [W-1:0]   r_coef [NC];
    logic signed [W-1:0]   r_x1 [NSEC];
    logic signed [W-1:0]   r_x2 [NSEC];
    logic signed [W-1:0]   r_y1 [NSEC];
    logic signed [W-1:0]   r_y2 [NSEC];

    logic [CAW-1:0]        w_cidx;
    logic signed [W-1:0]   w_data;
    logic signed [2*W-1:0] w_prod;
    logic signed [AW-1:0]  w_pext;
    logic signed [AW-1:0]  w_acc_nxt;
    logic signed [W-1:0]   w_y;
    logic                  w_sat;

    assign w_cidx = CAW'(r_sec * NTAP + r_tap);

    always_comb begin
        w_data = r_tap == TAP_B0 ? r_x :
                 r_tap == TAP_B1 ? r_x1[r_sec] :
                 r_tap == TAP_B2 ? r_x2[r_sec] :
                 r_tap == TAP_A1 ? r_y1[r_sec] : r_y2[r_sec];
    end

    assign w_prod = r_coef[w_cidx] * w_data;
    assign w_pext = AW'(w_prod);
    // tap 0 starts a fresh sum; feedback taps are subtracted since a0 = 1
    assign w_acc_nxt = r_tap == TAP_B0 ? w_pext :
                       r_tap >= TAP_A1 ? r_acc - w_pext : r_acc + w_pext;

    iir_round_sat #(.WI(WI), .WF(WF), .AW(AW)) u_rs (
        .i_acc (r_acc),
        .o_y   (w_y),
        .o_sat (w_sat)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_sec       <= '0;
            r_tap       <= '0;
            r_acc       <= '0;
            r_x         <= '0;
            r_dout      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_ovf       <= 1'b0;
            for (int k = 0; k < NC; k++)
                r_coef[k] <= (k % NTAP == 0) ? ONE : '0;
            for (int k = 0; k < NSEC; k++) begin
                r_x1[k] <= '0;
                r_x2[k] <= '0;
                r_y1[k] <= '0;
                r_y2[k] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_coef_we && int'(i_coef_addr) < NC)
                        r_coef[i_coef_addr] <= i_coef_data;
                    if (i_clear_state) begin
                        r_ovf <= 1'b0;
                        for (int k = 0; k < NSEC; k++) begin
                            r_x1[k] <= '0;
                            r_x2[k] <= '0;
                            r_y1[k] <= '0;
                            r_y2[k] <= '0;
                        end
                    end
                    if (i_in_valid) begin
                        r_x        <= i_din;
                        r_sec      <= '0;
                        r_tap      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_MAC;
                    end
                end
                S_MAC: begin
                    r_acc <= w_acc_nxt;
                    r_tap <= r_tap + 3'd1;
                    if (r_tap == TAP_A2)
                        r_state <= S_WB;
                end
                S_WB: begin
                    r_x1[r_sec] <= r_x;
                    r_x2[r_sec] <= r_x1[r_sec];
                    r_y1[r_sec] <= w_y;
                    r_y2[r_sec] <= r_y1[r_sec];
                    r_x         <= w_y;
                    r_tap       <= '0;
                    if (w_sat)
                        r_ovf <= 1'b1;
                    if (r_sec == SW'(NSEC - 1)) begin
                        r_dout      <= w_y;
                        r_out_valid <= 1'b1;
                        r_state     <= S_OUT;
                    end else begin
                        r_sec   <= r_sec + 1'b1;
                        r_state <= S_MAC;
                    end
                end
                S_OUT: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_dout      = r_dout;
    assign o_ovf       = r_ovf;
endmodule

// File: tb/tb_iir_sos_cascade.sv
// tb_iir_sos_cascade: scoreboard bench for the NSEC=4, Q5.11 SOS cascade
module tb_iir_sos_cascade;
    localparam int NSEC = 4;
    localparam int NC   = 5 * NSEC;
    localparam int LAT  = 6 * NSEC + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] din = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] dout;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        coef_we = 1'b0;
    logic [4:0]  coef_addr = '0;
    logic [15:0] coef_data = '0;
    logic        clear_state = 1'b0;
    logic        ovf;

    always #5 clk = ~clk;

    iir_sos_cascade #(.NSEC(NSEC), .WI(5), .WF(11), .GUARD(4)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_din         (din),
        .i_in_valid    (in_valid),
        .o_in_ready    (in_ready),
        .o_dout        (dout),
        .o_out_valid   (out_valid),
        .i_out_ready   (out_ready),
        .i_coef_we     (coef_we),
        .i_coef_addr   (coef_addr),
        .i_coef_data   (coef_data),
        .i_clear_state (clear_state),
        .o_ovf         (ovf)
    );

    int n_vec = 0;
    int n_err = 0;
    int q[$];
    int m_coef[NC];
    int m_x1[NSEC], m_x2[NSEC], m_y1[NSEC], m_y2[NSEC];
    bit m_ovf;

    task automatic check(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int s = 0; s < NSEC; s++) begin
            m_x1[s] = 0; m_x2[s] = 0; m_y1[s] = 0; m_y2[s] = 0;
        end
        m_ovf = 0;
    endtask

    task automatic reset_model();
        for (int k = 0; k < NC; k++) m_coef[k] = (k % 5 == 0) ? 2048 : 0;
        clear_model();
    endtask

    function automatic int model(input int xin);
        int x = xin;
        longint acc, y;
        for (int s = 0; s < NSEC; s++) begin
            acc = longint'(m_coef[5*s]) * x + longint'(m_coef[5*s+1]) * m_x1[s]
                + longint'(m_coef[5*s+2]) * m_x2[s] - longint'(m_coef[5*s+3]) * m_y1[s]
                - longint'(m_coef[5*s+4]) * m_y2[s];
            y = (acc + 1024) >>> 11;
            if (y > 32767) begin y = 32767; m_ovf = 1; end
            else if (y < -32768) begin y = -32768; m_ovf = 1; end
            m_x2[s] = m_x1[s]; m_x1[s] = x;
            m_y2[s] = m_y1[s]; m_y1[s] = int'(y);
            x = int'(y);
        end
        return x;
    endfunction

    task automatic wcoef(input int addr, input int val);
        @(negedge clk);
        coef_we = 1'b1; coef_addr = 5'(addr); coef_data = 16'(val);
        @(negedge clk);
        coef_we = 1'b0;
        m_coef[addr] = val;
    endtask

    task automatic clear();
        @(negedge clk);
        clear_state = 1'b1;
        @(negedge clk);
        clear_state = 1'b0;
        clear_model();
    endtask

    task automatic send(input int x, input bit clr);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) begin check("send_timeout", 1, 0); return; end
        din = 16'(x); in_valid = 1'b1; clear_state = clr;
        if (clr) clear_model();
        q.push_back(model(x));
        @(negedge clk);
        in_valid = 1'b0; clear_state = 1'b0;
    endtask

    task automatic recv(input string tag, input int lat_exp, output int got);
        int c = 1;
        int exp;
        got = 0;
        while (!out_valid && c < 400) begin @(negedge clk); c++; end
        if (!out_valid) begin check({tag, "_timeout"}, 1, 0); return; end
        if (lat_exp > 0) check({tag, "_latency"}, c, lat_exp);
        exp = q.pop_front();
        got = int'($signed(dout));
        check(tag, got, exp);
        check({tag, "_ovf"}, ovf, m_ovf);
        @(negedge clk);
        check({tag, "_in_ready_after"}, in_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int got, held, c;
        bit phantom;
        reset_model();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_dout", dout, 0);
        check("rst_ovf", ovf, 0);

        send('h1234, 0); recv("pass", LAT, got); check("pass_const", got, 'h1234);
        send(-5, 0);     recv("pass_neg", LAT, got); check("pass_neg_const", got, -5);
        send(32767, 0);  recv("pass_max", LAT, got);
        send(-32768, 0); recv("pass_min", LAT, got);

        wcoef(0, 1024); wcoef(3, -1024);
        send(2048, 1); recv("imp0", LAT, got); check("imp0_const", got, 1024);
        send(0, 0);    recv("imp1", LAT, got); check("imp1_const", got, 512);
        send(0, 0);    recv("imp2", LAT, got); check("imp2_const", got, 256);
        send(0, 0);    recv("imp3", LAT, got); check("imp3_const", got, 128);

        wcoef(0, 2048); wcoef(3, 0);
        wcoef(5, 1500); wcoef(6, -700); wcoef(7, 300); wcoef(8, -400); wcoef(9, 200);
        wcoef(10, 1800); wcoef(13, 300);
        for (int i = 0; i < 8; i++) begin
            send(int'($urandom_range(0, 40000)) - 20000, 0);
            recv("mix", LAT, got);
        end
        wcoef(5, 2048); wcoef(6, 0); wcoef(7, 0); wcoef(8, 0); wcoef(9, 0);
        wcoef(10, 2048); wcoef(13, 0);

        wcoef(0, 32767);
        send(32767, 1); recv("sat", LAT, got);
        check("sat_const", got, 32767);
        check("sat_ovf", ovf, 1);
        clear();
        check("ovf_cleared", ovf, 0);
        wcoef(0, 2048);

        send('h0321, 1);
        repeat (3) @(negedge clk);
        coef_we = 1'b1; coef_addr = 5'd0; coef_data = 16'd0;
        @(negedge clk);
        coef_we = 1'b0;
        recv("busy0", 0, got); check("busy0_const", got, 'h0321);
        send('h0456, 0); recv("busy1", LAT, got); check("busy1_const", got, 'h0456);

        out_ready = 1'b0;
        send('h0777, 0);
        c = 0;
        while (!out_valid && c < 400) begin @(negedge clk); c++; end
        check("bp_valid", out_valid, 1);
        held = int'($signed(dout));
        check("bp_value", held, q.pop_front());
        repeat (10) begin
            @(negedge clk);
            in_valid = 1'b1; din = 16'h1111;
            check("bp_dout", int'($signed(dout)), held);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", in_ready, 1);
        check("bp_release_out_valid", out_valid, 0);
        phantom = 0;
        repeat (30) begin @(negedge clk); if (out_valid) phantom = 1; end
        check("bp_no_accept", phantom, 0);

        wcoef(0, 1024);
        send('h0100, 0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        q.delete();
        reset_model();
        send('h2345, 0); recv("after_rst", LAT, got); check("after_rst_const", got, 'h2345);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/iir_sos_cascade.md
# iir_sos_cascade

Parametrised cascade of NSEC Direct-Form-I second-order IIR sections. It is time-multiplexed onto a single signed multiplier-accumulator and driven by a small FSM. It supersedes the single fixed biquad: section count, data format and guard bits are parameters, and it adds a run-time coefficient write port, a valid/ready stream handshake, round-and-saturate between sections and a sticky overflow flag. It sits in the DSP datapath between the sample source and downstream filter stages.

## Interface
- NSEC, 4: number of cascaded biquad sections (1..16).
- WI, 5: integer bits of data and coefficients, sign included.
- WF, 11: fraction bits of data and coefficients.
- GUARD, 4: accumulator guard bits.
- CLK  in  1  clock; all logic on the rising edge.
- RST  in  1  reset, synchronous and active-high.
- din  in  WI+WF  signed input sample, Q(WI.WF).
- in_valid  in  1  din is valid.
- in_ready  out  1  block accepts a sample; high only in IDLE.
- dout  out  WI+WF  signed output sample, Q(WI.WF).
- out_valid  out  1  dout is valid.
- out_ready  in  1  downstream accepts dout.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  clog2(5*NSEC)  address = section*5 + tap; taps are 0=b0, 1=b1, 2=b2, 3=a1, 4=a2.
- coef_data  in  WI+WF  signed coefficient, Q(WI.WF).
- clear_state  in  1  zeroes the delay lines and ovf; honoured in IDLE only.
- ovf  out  1  sticky overflow flag.

## Operation
- Each section computes y = b0·x + b1·x1 + b2·x2 − a1·y1 − a2·y2, with a0 implicitly 1. Section k input is section k−1 output.
- Accumulator width: 2(WI+WF)+GUARD, signed; it sums full-precision products.
- Write-back per section: add 2^(WF−1) (round half up), arithmetic shift right by WF, then saturate to [−2^(WI+WF−1), 2^(WI+WF−1)−1].
- Saturation sets ovf. ovf is cleared only by RST or by clear_state in IDLE.
- FSM states:
  - IDLE: in_ready=1. in_valid&in_ready latches din and goes to MAC with sec=0, tap=0.
  - MAC: one product accumulated per cycle, tap 0..4. After tap 4, go to WB.
  - WB: round/saturate; shift the section's x and y delay lines; the result becomes the next section's x. If sec=NSEC−1, load dout and go to OUT; otherwise sec+1 and go to MAC.
  - OUT: out_valid=1 and dout held stable until out_ready; then go to IDLE.
- Coefficient writes are accepted in IDLE only. In any other state they are silently dropped.
- Delay lines are 4·NSEC registers of WI+WF bits.
- RST values:
  - state=IDLE, in_ready=1, out_valid=0, dout=0, ovf=0.
  - All delay lines 0.
  - Coefficients: every b0 = 2^WF (1.0), all other taps 0, so the block resets to passthrough.
- RST mid-operation: the in-flight sample is discarded and the reset values above apply on the next cycle.
- clear_state together with in_valid in IDLE: clear is applied first, and the sample is accepted against zeroed state.

## Timing
- Sample accepted at cycle t. The MAC for section s occupies cycles t+1+6s .. t+5+6s, and WB is at t+6+6s.
- out_valid rises at cycle t+1+6·NSEC; that is t+25 for NSEC=4.
- in_ready returns high the cycle after the out_valid&out_ready handshake.
- Maximum throughput: one sample per 6·NSEC+2 cycles with out_ready held high.
- A coefficient write in IDLE takes effect on the next accepted sample.

## Structure
- Package iir_pkg holds:
  - the FSM state enum (IDLE, MAC, WB, OUT);
  - localparam NTAP=5 and the tap index constants;
  - the accumulator-width function.
- Sub-module iir_round_sat: combinational round, shift and saturate from the accumulator width to WI+WF. It outputs the saturated value and a sat flag, and is reused by later filter blocks.
- Coefficient and delay storage are plain register arrays; a 16-bit word with WI=5 and WF=11 is assumed only in the test plan.

## Test plan
- Passthrough: after RST, send din=0x1234 → dout=0x1234 at t+25 (NSEC=4), ovf=0.
- Impulse, NSEC=1: set b0=1024 (0.5) and a1=−1024 (−0.5); send x=2048, 0, 0, 0 → dout=1024, 512, 256, 128.
- Saturation: b0=0x7FFF in section 0, din=0x7FFF → dout=0x7FFF and ovf=1. Then clear_state in IDLE → ovf=0.
- Busy write drop: coef_we during MAC with b0:=0 → the current and next outputs are unchanged from the passthrough value.
- Backpressure: out_ready low for 10 cycles after out_valid → dout stable, in_ready=0, a second in_valid is not accepted. Then out_ready=1 → in_ready=1 on the next cycle.
- Reset mid-operation: assert RST at t+10 → next cycle shows out_valid=0, in_ready=1, coefficients back to passthrough, and the next sample is passed unchanged.
